// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 set-2 make/break byte stream for keys A,S,J,K with 00 gaps.
// Optional TYPEMATIC_EN builds a make-code repeat timer for the last key pressed.
module ps2_key_encoder #(
  parameter int HOLD_CYCLES   = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keys,
  output logic [7:0] code,
  output logic       strobe,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, PFX, PGAP, CODE, CGAP} state_t;
  localparam logic [23:0] HOLD = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] GAP  = 24'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] s1, ks, rep, pending;
  logic [1:0] k, k_n, last_k;
  logic mk, mk_n, done, rpt_go, strobe_n;
  logic [23:0] cnt, cnt_n;
  logic [7:0] code_n;
  assign pending = ks ^ rep;
  assign done = cnt == 24'd0;
`ifdef TYPEMATIC_EN
  localparam logic [23:0] REP = 24'(REPEAT_CYCLES - 1);
  logic [23:0] rpt;
  always_ff @(posedge clk)
    if (!rst) begin
      rpt <= 24'd0;
      last_k <= 2'd0;
    end else if (state_n == CODE && state != CODE && mk_n) begin
      rpt <= REP;
      last_k <= k_n;
    end else if (rpt != 24'd0) rpt <= rpt - 24'd1;
  // a release of last_k clears rep[last_k], which cancels the repeat
  assign rpt_go = rpt == 24'd0 && rep[last_k];
`else
  assign last_k = 2'd0;
  assign rpt_go = REPEAT_CYCLES < 0;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      s1 <= 4'd0;
      ks <= 4'd0;
      rep <= 4'd0;
      k <= 2'd0;
      mk <= 1'b0;
      cnt <= 24'd0;
      code <= 8'h00;
      strobe <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      s1 <= keys;
      ks <= s1;
      k <= k_n;
      mk <= mk_n;
      cnt <= cnt_n;
      code <= code_n;
      strobe <= strobe_n;
      busy <= state_n != IDLE;
      if (state == CGAP && done) rep[k] <= mk;
    end
  always_comb begin
    state_n = state;
    k_n = k;
    mk_n = mk;
    cnt_n = done ? cnt : cnt - 24'd1;
    case (state)
      IDLE:
        if (pending != 4'd0) begin
          k_n = pending[3] ? 2'd3 : pending[2] ? 2'd2 : pending[1] ? 2'd1 : 2'd0;
          mk_n = ks[k_n];
          state_n = mk_n ? CODE : PFX;
          cnt_n = HOLD;
        end else if (rpt_go) begin
          k_n = last_k;
          mk_n = 1'b1;
          state_n = CODE;
          cnt_n = HOLD;
        end
      PFX:  if (done) begin state_n = PGAP; cnt_n = GAP; end
      PGAP: if (done) begin state_n = CODE; cnt_n = HOLD; end
      CODE: if (done) begin state_n = CGAP; cnt_n = GAP; end
      CGAP: if (done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are computed from the next state so they come out registered
  always_comb begin
    code_n = state_n == PFX ? 8'hF0 :
             state_n != CODE ? 8'h00 :
             k_n == 2'd3 ? 8'h1C : k_n == 2'd2 ? 8'h1B : k_n == 2'd1 ? 8'h3B : 8'h42;
    strobe_n = (state_n == PFX || state_n == CODE) && state_n != state;
  end
endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed and random key activity checked cycle by cycle against
// a sequence-expanding reference model of the scan-code stream.
module tb_ps2_key_encoder;
  localparam int H = 4, G = 4, R = 100;
  logic clk = 0, rst = 0;
  logic [3:0] keys = 0;
  logic [7:0] code;
  logic strobe, busy;
  int total = 0, bad = 0;

  ps2_key_encoder #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .keys(keys), .code(code), .strobe(strobe), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {logic [7:0] c; logic s;} ent_t;
  ent_t q[$];
  ent_t e;
  logic [3:0] h1 = 0, mks = 0, mrep = 0;
  logic [7:0] e_code = 0;
  logic e_strobe = 0, e_busy = 0;
  bit upd = 0, ud = 0, go, dir;
  int uk = 0, last_k = 0, kk;
  longint t = 0, last_make = -1000000;

  function automatic logic [7:0] kc(int i);
    return i == 3 ? 8'h1C : i == 2 ? 8'h1B : i == 1 ? 8'h3B : 8'h42;
  endfunction

  task automatic push_byte(logic [7:0] b);
    for (int i = 0; i < H; i++) q.push_back('{b, i == 0});
    for (int i = 0; i < G; i++) q.push_back('{8'h00, 1'b0});
  endtask

  // model: each serviced key expands to its whole byte sequence; rep is updated once it drains
  always @(posedge clk) begin
    t++;
    if (!rst) begin
      q.delete();
      h1 = 0; mks = 0; mrep = 0; upd = 0;
      last_make = -1000000; last_k = 0;
      e_code = 0; e_strobe = 0; e_busy = 0;
    end else begin
      if (q.size() == 0) begin
        if (upd) begin
          mrep[uk] = ud;
          upd = 0;
        end else begin
          go = 0; kk = 0; dir = 0;
          for (int i = 0; i < 4; i++) if ((mks[i] ^ mrep[i]) == 1'b1) begin kk = i; go = 1; end
          if (go) dir = mks[kk];
`ifdef TYPEMATIC_EN
          if (!go && mrep[last_k] && t - last_make >= R) begin kk = last_k; dir = 1; go = 1; end
`endif
          if (go) begin
            if (!dir) push_byte(8'hF0);
            push_byte(kc(kk));
            if (dir) begin last_make = t; last_k = kk; end
            uk = kk; ud = dir; upd = 1;
          end
        end
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        e_code = e.c; e_strobe = e.s; e_busy = 1;
      end else begin
        e_code = 0; e_strobe = 0; e_busy = 0;
      end
      mks = h1;
      h1 = keys;
    end
  end

  task automatic test_reset();
    rst = 0;
    keys = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== 10'd0) begin
        bad++;
        $display("FAIL reset cyc%0d: got code=%h strobe=%b busy=%b want 00/0/0", i, code, strobe, busy);
      end
    end
    rst = 1;
  endtask

  task automatic test_make();
    int st = 0, bz = 0;
    keys = 4'b1000;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL make cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      if (i == 3) begin
        total++;
        if (code !== 8'h1C || strobe !== 1'b1) begin
          bad++;
          $display("FAIL make_first: got %h/%b want 1c/1", code, strobe);
        end
      end
      st += int'(strobe);
      bz += int'(busy);
    end
    total++;
    if (st != 1 || bz != H + G) begin
      bad++;
      $display("FAIL make_counts: strobes=%0d busy=%0d want 1 and %0d", st, bz, H + G);
    end
  endtask

  task automatic test_break();
    int st = 0;
    keys = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL break cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      if (i == 3 || i == 11) begin
        total++;
        if (code !== (i == 3 ? 8'hF0 : 8'h1C)) begin
          bad++;
          $display("FAIL break_byte cyc%0d: got %h", i, code);
        end
      end
      st += int'(strobe);
    end
    total++;
    if (st != 2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL break_end: strobes=%0d busy=%b want 2 and 0", st, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit f0 = 0;
    keys = 4'b0011;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL b2b cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      if (i == 3 || i == 11 || i == 12) begin
        total++;
        if ({code, busy} !== (i == 3 ? {8'h3B, 1'b1} : i == 11 ? {8'h00, 1'b0} : {8'h42, 1'b1})) begin
          bad++;
          $display("FAIL b2b_slot cyc%0d: got code=%h busy=%b", i, code, busy);
        end
      end
      if (code === 8'hF0) f0 = 1;
    end
    total++;
    if (f0) begin
      bad++;
      $display("FAIL b2b_no_f0: got F0 byte want none");
    end
    keys = 4'b0000;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL b2b_rel cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
    end
  endtask

  task automatic test_short_pulse();
    bit seen = 0;
    keys = 4'b1000;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL pulse cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      if (code === 8'h1B || code === 8'hF0) seen = 1;
      if (i == 4) keys = 4'b1100;
      if (i == 6) keys = 4'b1000;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL pulse_swallowed: got 1B/F0 byte want none");
    end
    keys = 4'b0000;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL pulse_rel cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int st = 0;
    keys = 4'b1000;
    repeat (12) @(negedge clk);
    keys = 4'b0000;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL rstmid cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      if (i == 9) begin
        total++;
        if ({code, busy} !== 9'd0) begin
          bad++;
          $display("FAIL rstmid_abort: got code=%h busy=%b want 00/0", code, busy);
        end
      end
      if (i == 8) rst = 0;
    end
    rst = 1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      st += int'(strobe);
    end
    total++;
    if (st != 0 || code !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_quiet: strobes=%0d code=%h want 0 and 00", st, code);
    end
    keys = 4'b1000;
    rst = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL held cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      if (i == 3) begin
        total++;
        if (code !== 8'h1C) begin
          bad++;
          $display("FAIL held_make: got %h want 1c", code);
        end
      end
    end
    keys = 4'b0000;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL random cyc%0d: keys=%b got %h/%b/%b want %h/%b/%b", i, keys, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      if ($urandom_range(0, 11) == 0) keys = 4'($urandom);
    end
    keys = 4'b0000;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL random_drain cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
    end
  endtask

`ifdef TYPEMATIC_EN
  task automatic test_typematic();
    int st = 0;
    keys = 4'b0001;
    for (int i = 1; i <= 350; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL typ cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      st += int'(strobe);
    end
    total++;
    if (st != 4) begin
      bad++;
      $display("FAIL typ_repeats: strobes=%0d want 4", st);
    end
    st = 0;
    keys = 4'b0000;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clk);
      total++;
      if ({code, strobe, busy} !== {e_code, e_strobe, e_busy}) begin
        bad++;
        $display("FAIL typ_rel cyc%0d: got %h/%b/%b want %h/%b/%b", i, code, strobe, busy, e_code, e_strobe, e_busy);
      end
      st += int'(strobe);
    end
    total++;
    if (st != 2) begin
      bad++;
      $display("FAIL typ_cancel: strobes=%0d want 2", st);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_make();
    test_break();
    test_back_to_back();
    test_short_pulse();
    test_reset_mid();
    test_random();
`ifdef TYPEMATIC_EN
    test_typematic();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
